dac: RTL
========

# dac

10-bit SPI DAC writer for an MCP4911-class converter: the output-side counterpart of the 10-bit SPI ADC sampler on the same board. It accepts a 10-bit sample through a valid/ready handshake and builds the 16-bit write command. It shifts the command out MSB-first in SPI mode 0, then pulses LDAC so the analog output updates. It sits between the NBBPU output path (or a test pattern source) and the DAC pins.

## Interface
- CLOCK_DIV, 16'h00FF: half-period divider. One SCK half-period H = CLOCK_DIV+1 clock cycles; 0 is legal (H=1).
- BUF, 1'b0: value placed in command bit 14 (VREF buffer enable).
- GAIN_1X, 1'b1: value placed in command bit 13 (GA_n; 1 selects 1x gain).
- clock  input  1  system clock (12 MHz on board); one clock only.
- reset  input  1  synchronous, active-high reset.
- valid  input  1  sample is offered.
- sample  input  10  DAC code; captured only on handshake.
- ready  output  1  high only in IDLE; valid&&ready in the same cycle accepts the sample.
- done  output  1  one-cycle pulse on the last cycle of the LDAC phase.
- dac_cs_n  output  1  chip select, active low.
- dac_sck  output  1  serial clock, idle low.
- dac_sdi  output  1  serial data to DAC, changes only while dac_sck is low.
- dac_ldac_n  output  1  latch strobe, active low.

## Operation
- Frame on accept: {1'b0, BUF, GAIN_1X, 1'b1 (SHDN_n), sample[9:0], 2'b00}. Frame bit 15 is sent first.
- The sample is registered at the handshake. Later changes on `sample` are ignored until the next handshake.
- States: IDLE, SETUP, SCK_HI, SCK_LO, CS_END, LDAC. Every non-IDLE state lasts exactly H cycles, timed by a 16-bit counter that runs from 0 to CLOCK_DIV and then advances the state.
- IDLE: cs_n=1, sck=0, sdi=0, ldac_n=1, ready=1. On valid, go to SETUP.
- SETUP: cs_n=0, sdi=frame[15]. Next state is SCK_HI.
- SCK_HI: sck=1; the DAC samples sdi on this rising edge. After the 16th SCK_HI, go to CS_END; otherwise go to SCK_LO.
- SCK_LO: sck=0; sdi takes the next frame bit on the first cycle of the state. Next state is SCK_HI.
- A 4-bit bit counter counts SCK_HI phases from 0 to 15.
- CS_END: cs_n=1, sck=0, sdi=0. Next state is LDAC.
- LDAC: ldac_n=0. done=1 on its final cycle. Next state is IDLE.
- valid outside IDLE is ignored; samples are not queued. Back-to-back transfers are allowed: valid held high is accepted on the first IDLE cycle.
- Reset, including mid-frame, forces IDLE at the next edge. The partial frame is abandoned, with no LDAC pulse and no done.

## Timing
- Reset values: ready=1, done=0, dac_cs_n=1, dac_sck=0, dac_sdi=0, dac_ldac_n=1. Counters are 0.
- valid is ignored in the cycle where reset is high.
- All outputs are registered, glitch-free, and change only on posedge clock.
- Take the handshake at cycle 0:
  - dac_cs_n falls at cycle 1.
  - The first dac_sck rise is at cycle H+1.
  - Rising edge k (k=1..16) is at cycle (2k-1)H+1.
  - dac_cs_n rises at cycle 32H+1.
  - dac_ldac_n is low for cycles 33H+1 through 34H.
  - done is high at cycle 34H.
  - ready is high again at cycle 34H+1.
- Total period is 34H+1 cycles per sample. With the default H=256 that is 8705 cycles, about 1.38 kS/s at 12 MHz, which matches the ADC sample rate.
- SDI setup time before a rising SCK edge is at least H cycles. SDI hold time after the edge is H cycles.

## Test plan
- CLOCK_DIV=1, sample=10'h3FF, valid for one cycle:
  - The SDI bits captured on the 16 SCK rises equal 16'h3FFC.
  - cs_n is low for cycles 1..64.
  - ldac_n is low for cycles 67..68, done at cycle 68, ready at cycle 69.
- CLOCK_DIV=0, sample=10'h155, BUF=1:
  - Captured frame = 16'h7554.
  - Each SCK high and low phase is exactly 1 cycle.
- Hold valid with sample=10'h001, then 10'h200: two frames 16'h3004 and 16'h3800 are sent. Exactly 1 IDLE cycle separates LDAC from the next cs_n fall.
- Pulse valid mid-frame with a different sample: it is ignored, the frame is unchanged, and ready stays low.
- Assert reset for one cycle during the 8th SCK_HI:
  - The next cycle shows cs_n=1, sck=0, sdi=0, ldac_n=1, ready=1.
  - No done pulse occurs.
  - The next valid starts a clean frame.
- Default CLOCK_DIV (H=256):
  - The handshake-to-ready period is 8705 cycles.
  - Every SCK half-period measures 256 cycles.
  - SDI never changes while sck=1.

Source files
------------

// File: rtl/dac.sv
// rtl/dac.sv - 10-bit SPI DAC writer (MCP4911-class), mode 0, with LDAC strobe.
// Accepts a sample on valid/ready, shifts the 16-bit write command MSB-first, then pulses LDAC.
module dac #(
  parameter logic [15:0] CLOCK_DIV = 16'h00FF,
  parameter logic        BUF       = 1'b0,
  parameter logic        GAIN_1X   = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid,
  input  logic [9:0] sample,
  output logic       ready,
  output logic       done,
  output logic       dac_cs_n,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ldac_n
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    CS_END = 3'd4,
    LDAC   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        sdi_q, sdi_d;
  logic        ldac_n_q, ldac_n_d;

  logic [15:0] frame;
  logic        phase_end;
  logic        in_frame;

  assign frame     = {1'b0, BUF, GAIN_1X, 1'b1, sample, 2'b00};
  assign phase_end = (cnt_q == CLOCK_DIV);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (state_q == IDLE) begin
      cnt_d = 16'd0;
      bit_d = 4'd0;
      if (valid) begin
        state_d = SETUP;
        shift_d = frame;
      end
    end else if (!phase_end) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = 16'd0;
      case (state_q)
        SETUP:  state_d = SCK_HI;
        SCK_HI: begin
          if (bit_q == 4'd15) begin
            state_d = CS_END;
            bit_d   = 4'd0;
          end else begin
            state_d = SCK_LO;
            bit_d   = bit_q + 4'd1;
            shift_d = {shift_q[14:0], 1'b0};
          end
        end
        SCK_LO: state_d = SCK_HI;
        CS_END: state_d = LDAC;
        LDAC:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    in_frame = (state_d == SETUP) || (state_d == SCK_HI) || (state_d == SCK_LO);
    ready_d  = (state_d == IDLE);
    done_d   = (state_d == LDAC) && (cnt_d == CLOCK_DIV);
    cs_n_d   = !in_frame;
    sck_d    = (state_d == SCK_HI);
    sdi_d    = in_frame ? shift_d[15] : 1'b0;
    ldac_n_d = (state_d != LDAC);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      bit_q    <= 4'd0;
      shift_q  <= 16'd0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      sdi_q    <= 1'b0;
      ldac_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      cs_n_q   <= cs_n_d;
      sck_q    <= sck_d;
      sdi_q    <= sdi_d;
      ldac_n_q <= ldac_n_d;
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign dac_cs_n   = cs_n_q;
  assign dac_sck    = sck_q;
  assign dac_sdi    = sdi_q;
  assign dac_ldac_n = ldac_n_q;

endmodule
